// File: rtl/sa_out_drainer.sv
// Ping-pong result drainer behind SA_wrapper: captures whole output matrices on the
// rising edge of the valid strobe and streams them out one row per valid/ready handshake.
module sa_out_drainer_bank #(
  parameter int D_W  = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  parameter int RW   = 4
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    din,
  input  logic [RW-1:0]                         rd_idx,
  output logic [0:SA_C-1][D_W-1:0]              row
);
  // Bulk data storage carries no reset; control never depends on its contents.
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem <= din;

  assign row = mem[rd_idx];
endmodule

module sa_out_drainer #(
  parameter int D_W  = 8,
  parameter int SA_R = 16,
  parameter int SA_C = 16,
  localparam int RW  = (SA_R > 1) ? $clog2(SA_R) : 1
) (
  input  logic                                  I_CLK,
  input  logic                                  I_ASYN_RSTN,
  input  logic                                  I_OUT_VLD,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    I_OUT,
  output logic                                  O_ROW_VLD,
  input  logic                                  I_ROW_RDY,
  output logic [0:SA_C-1][D_W-1:0]              O_ROW,
  output logic [RW-1:0]                         O_ROW_IDX,
  output logic                                  O_ROW_LAST,
  output logic                                  O_FULL,
  output logic                                  O_OVERFLOW
);
  localparam logic [RW-1:0] LAST_ROW = RW'(SA_R - 1);

  logic                              prev_vld;
  logic                              wr_ptr;
  logic                              rd_ptr;
  logic [1:0]                        cnt;
  logic [RW-1:0]                     row_idx;
  logic                              overflow;
  logic                              cap_evt;
  logic                              hs;
  logic                              last_hs;
  logic                              accept;
  logic [1:0]                        bank_we;
  logic [1:0][0:SA_C-1][D_W-1:0]     bank_row;

  assign cap_evt = I_OUT_VLD & ~prev_vld;
  assign hs      = O_ROW_VLD & I_ROW_RDY;
  assign last_hs = hs & (row_idx == LAST_ROW);
  // A full drainer still accepts when the draining bank frees in this same cycle.
  assign accept  = cap_evt & ((cnt != 2'd2) | last_hs);
  assign bank_we = accept ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sa_out_drainer_bank #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .RW(RW)) u_bank (
      .clk    (I_CLK),
      .we     (bank_we[b]),
      .din    (I_OUT),
      .rd_idx (row_idx),
      .row    (bank_row[b])
    );
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      prev_vld <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      row_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      prev_vld <= I_OUT_VLD;
      if (accept) wr_ptr <= ~wr_ptr;
      if (cap_evt && !accept) overflow <= 1'b1;
      if (hs) begin
        if (row_idx == LAST_ROW) begin
          row_idx <= '0;
          rd_ptr  <= ~rd_ptr;
        end else begin
          row_idx <= row_idx + 1'b1;
        end
      end
      case ({accept, last_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign O_ROW_VLD  = (cnt != 2'd0);
  assign O_ROW      = bank_row[rd_ptr];
  assign O_ROW_IDX  = row_idx;
  assign O_ROW_LAST = O_ROW_VLD & (row_idx == LAST_ROW);
  assign O_FULL     = (cnt == 2'd2);
  assign O_OVERFLOW = overflow;
endmodule

// File: tb/tb_sa_out_drainer.sv
// Scoreboard bench for sa_out_drainer: expected rows are queued when a matrix is
// driven and popped by a negedge monitor on every row handshake.
module tb_sa_out_drainer;
  localparam int D_W  = 8;
  localparam int SA_R = 16;
  localparam int SA_C = 16;
  localparam int RW   = $clog2(SA_R);
  localparam int RB   = SA_C * D_W;

  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0] mat_t;
  typedef struct {
    logic [RB-1:0] row;
    logic [RW-1:0] idx;
    logic          last;
  } exp_t;

  logic                          I_CLK;
  logic                          I_ASYN_RSTN;
  logic                          I_OUT_VLD;
  mat_t                          I_OUT;
  logic                          O_ROW_VLD;
  logic                          I_ROW_RDY;
  logic [0:SA_C-1][D_W-1:0]      O_ROW;
  logic [RW-1:0]                 O_ROW_IDX;
  logic                          O_ROW_LAST;
  logic                          O_FULL;
  logic                          O_OVERFLOW;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;

  sa_out_drainer #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
    .I_CLK       (I_CLK),
    .I_ASYN_RSTN (I_ASYN_RSTN),
    .I_OUT_VLD   (I_OUT_VLD),
    .I_OUT       (I_OUT),
    .O_ROW_VLD   (O_ROW_VLD),
    .I_ROW_RDY   (I_ROW_RDY),
    .O_ROW       (O_ROW),
    .O_ROW_IDX   (O_ROW_IDX),
    .O_ROW_LAST  (O_ROW_LAST),
    .O_FULL      (O_FULL),
    .O_OVERFLOW  (O_OVERFLOW)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  function automatic mat_t fill_const(input logic [D_W-1:0] v);
    mat_t m;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t fill_ramp(input logic [D_W-1:0] x);
    mat_t m;
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) m[r][c] = D_W'(r * 16 + c) ^ x;
    return m;
  endfunction

  task automatic push_mat(input mat_t m);
    exp_t e;
    for (int r = 0; r < SA_R; r++) begin
      e.row  = m[r];
      e.idx  = RW'(r);
      e.last = (r == SA_R - 1);
      exp_q.push_back(e);
    end
  endtask

  // One-cycle strobe pulse followed by one low cycle.
  task automatic cap(input mat_t m);
    I_OUT     = m;
    I_OUT_VLD = 1'b1;
    tick();
    I_OUT_VLD = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, RB'(exp_q.size()), RB'(0));
  endtask

  task automatic do_reset();
    I_ASYN_RSTN = 1'b0;
    I_OUT_VLD   = 1'b0;
    I_ROW_RDY   = 1'b0;
    tick();
    tick();
    exp_q.delete();
    I_ASYN_RSTN = 1'b1;
  endtask

  // Monitor: scoreboard pop on handshake, plus hold-stability across stalls.
  initial begin
    logic          stall_d;
    logic [RB-1:0] held_row;
    logic [RW-1:0] held_idx;
    exp_t          e;
    stall_d = 1'b0;
    forever begin
      @(negedge I_CLK);
      if (!I_ASYN_RSTN) begin
        stall_d = 1'b0;
      end else begin
        if (stall_d && O_ROW_VLD) begin
          chk("stall_row", O_ROW, held_row);
          chk("stall_idx", RB'(O_ROW_IDX), RB'(held_idx));
        end
        if (O_ROW_VLD && I_ROW_RDY) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("extra_row", RB'(O_ROW_VLD), RB'(0));
          end else begin
            e = exp_q.pop_front();
            chk("row_data", O_ROW, e.row);
            chk("row_idx", RB'(O_ROW_IDX), RB'(e.idx));
            chk("row_last", RB'(O_ROW_LAST), RB'(e.last));
          end
        end
        stall_d  = O_ROW_VLD && !I_ROW_RDY;
        held_row = O_ROW;
        held_idx = O_ROW_IDX;
      end
    end
  end

  initial begin
    mat_t      m;
    int        hs0;
    logic [3:0] pat;
    I_OUT = '0;
    do_reset();

    // Reset state
    chk("rst_vld", RB'(O_ROW_VLD), RB'(0));
    chk("rst_idx", RB'(O_ROW_IDX), RB'(0));
    chk("rst_last", RB'(O_ROW_LAST), RB'(0));
    chk("rst_full", RB'(O_FULL), RB'(0));
    chk("rst_ovf", RB'(O_OVERFLOW), RB'(0));

    // Single matrix, strobe in the first cycle after reset release
    I_ROW_RDY = 1'b1;
    m = fill_ramp(8'h00);
    push_mat(m);
    I_OUT = m;
    I_OUT_VLD = 1'b1;
    tick();
    I_OUT_VLD = 1'b0;
    chk("cap_latency", RB'(O_ROW_VLD), RB'(1));
    wait_drain("single_drain");
    chk("single_idle", RB'(O_ROW_VLD), RB'(0));

    // Held strobe captures once
    hs0 = hs_cnt;
    m = fill_ramp(8'hA5);
    push_mat(m);
    I_OUT = m;
    I_OUT_VLD = 1'b1;
    repeat (40) tick();
    I_OUT_VLD = 1'b0;
    tick();
    wait_drain("held_drain");
    chk("held_hs", RB'(hs_cnt - hs0), RB'(16));
    chk("held_ovf", RB'(O_OVERFLOW), RB'(0));
    chk("held_idle", RB'(O_ROW_VLD), RB'(0));

    // Backpressure 1,0,0,1
    hs0 = hs_cnt;
    I_ROW_RDY = 1'b0;
    m = fill_ramp(8'h3C);
    push_mat(m);
    cap(m);
    pat = 4'b1001;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      I_ROW_RDY = pat[k % 4];
      tick();
    end
    I_ROW_RDY = 1'b0;
    chk("bp_empty", RB'(exp_q.size()), RB'(0));
    chk("bp_hs", RB'(hs_cnt - hs0), RB'(16));

    // Ping-pong and overflow
    cap(fill_const(8'h11));
    push_mat(fill_const(8'h11));
    chk("pp_notfull", RB'(O_FULL), RB'(0));
    cap(fill_const(8'h22));
    push_mat(fill_const(8'h22));
    chk("pp_full", RB'(O_FULL), RB'(1));
    chk("pp_noovf", RB'(O_OVERFLOW), RB'(0));
    cap(fill_const(8'h33));
    chk("pp_ovf", RB'(O_OVERFLOW), RB'(1));
    chk("pp_stillfull", RB'(O_FULL), RB'(1));
    I_ROW_RDY = 1'b1;
    wait_drain("pp_drain");
    chk("pp_idle", RB'(O_FULL), RB'(0));

    // Simultaneous final-row free and capture while full
    do_reset();
    cap(fill_const(8'h11));
    push_mat(fill_const(8'h11));
    cap(fill_const(8'h22));
    push_mat(fill_const(8'h22));
    chk("sim_full", RB'(O_FULL), RB'(1));
    I_ROW_RDY = 1'b1;
    repeat (15) tick();
    chk("sim_row15", RB'(O_ROW_LAST), RB'(1));
    I_OUT = fill_const(8'h44);
    push_mat(fill_const(8'h44));
    I_OUT_VLD = 1'b1;
    tick();
    I_OUT_VLD = 1'b0;
    chk("sim_full2", RB'(O_FULL), RB'(1));
    chk("sim_ovf", RB'(O_OVERFLOW), RB'(0));
    wait_drain("sim_drain");
    chk("sim_ovf_end", RB'(O_OVERFLOW), RB'(0));

    // Reset mid-drain
    I_ROW_RDY = 1'b1;
    I_OUT = fill_ramp(8'h0F);
    push_mat(fill_ramp(8'h0F));
    I_OUT_VLD = 1'b1;
    tick();
    I_OUT_VLD = 1'b0;
    repeat (7) tick();
    chk("pre_rst_idx", RB'(O_ROW_IDX), RB'(7));
    #1;
    I_ASYN_RSTN = 1'b0;
    #1;
    chk("mid_rst_vld", RB'(O_ROW_VLD), RB'(0));
    chk("mid_rst_idx", RB'(O_ROW_IDX), RB'(0));
    chk("mid_rst_last", RB'(O_ROW_LAST), RB'(0));
    chk("mid_rst_full", RB'(O_FULL), RB'(0));
    chk("mid_rst_ovf", RB'(O_OVERFLOW), RB'(0));
    exp_q.delete();
    tick();
    I_ASYN_RSTN = 1'b1;
    m = fill_ramp(8'hF0);
    push_mat(m);
    cap(m);
    wait_drain("post_rst_drain");
    chk("post_rst_idle", RB'(O_ROW_VLD), RB'(0));

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sa_out_drainer.md
# sa_out_drainer

Result drainer on the output side of `SA_wrapper`. It captures each completed SA_R x SA_C output matrix on the wrapper's output-valid strobe into one of two ping-pong banks. It then streams the matrix out one row per valid/ready handshake to the downstream consumer (softmax or memory writer). While one bank drains, the systolic array can finish the next tile.

## Interface
- `D_W`, 8, element width in bits
- `SA_R`, 16, rows per output matrix
- `SA_C`, 16, columns per output matrix (elements per streamed row)

Ports:
- `I_CLK`  in  1  clock; all logic on rising edge
- `I_ASYN_RSTN`  in  1  asynchronous, active-low reset
- `I_OUT_VLD`  in  1  output-valid from `SA_wrapper` (`O_OUT_VLD`)
- `I_OUT`  in  [D_W-1:0] x [0:SA_R-1][0:SA_C-1]  result matrix from `SA_wrapper` (`O_OUT`)
- `O_ROW_VLD`  out  1  a row is presented on `O_ROW`
- `I_ROW_RDY`  in  1  downstream accepts the row this cycle
- `O_ROW`  out  [D_W-1:0] x [0:SA_C-1]  current row, element c = matrix[row][c]
- `O_ROW_IDX`  out  $clog2(SA_R)  index of presented row
- `O_ROW_LAST`  out  1  presented row is row SA_R-1
- `O_FULL`  out  1  both banks occupied
- `O_OVERFLOW`  out  1  sticky: a matrix was dropped

## Operation
- Storage: two banks of SA_R x SA_C x D_W registers.
- Pointers: `wr_ptr` and `rd_ptr` (1 bit each), `cnt` (0..2), `row_idx` (0..SA_R-1).
- Capture event: `I_OUT_VLD` is 1 and its registered previous value is 0 (rising edge).
  - A level held high for many cycles captures exactly once.
  - A low-high-low-high sequence captures twice.
- Accept rule: a capture event is accepted when either:
  - `cnt < 2`, or
  - `cnt == 2` and the final-row handshake of `rd_ptr` bank occurs in the same cycle (freed slot is reused).
- On accept: `I_OUT` is copied into bank `wr_ptr`, and `wr_ptr` toggles.
- On non-accept: data is discarded, `O_OVERFLOW` is set to 1, and the banks and pointers are unchanged.
- Handshake: occurs when `O_ROW_VLD & I_ROW_RDY`.
  - If `row_idx < SA_R-1`, `row_idx` increments.
  - If `row_idx == SA_R-1` (final row), `row_idx` goes to 0, `rd_ptr` toggles, and the bank is freed.
- `cnt` update: accept and no final-row handshake gives +1; final-row handshake and no accept gives -1; both gives no change.
- `O_ROW_VLD` = (`cnt != 0`).
- `O_ROW` = bank[`rd_ptr`][`row_idx`], driven directly from storage registers with no extra pipeline stage.
- `O_ROW_IDX` = `row_idx`.
- `O_ROW_LAST` = `O_ROW_VLD & (row_idx == SA_R-1)`.
- `O_FULL` = (`cnt == 2`).
- While `O_ROW_VLD` is 1 and `I_ROW_RDY` is 0, `O_ROW`, `O_ROW_IDX` and `O_ROW_LAST` hold stable. A capture into the other bank does not disturb the presented row.
- `O_OVERFLOW` clears only on reset.
- No arithmetic on data; elements pass bit-exact.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - `cnt`, `row_idx`, `wr_ptr`, `rd_ptr` and the previous-`I_OUT_VLD` register go to 0.
  - `O_ROW_VLD`, `O_ROW_LAST`, `O_FULL`, `O_OVERFLOW` are 0, `O_ROW_IDX` is 0.
  - Bank contents are don't-care but `O_ROW` must not be X-gated into control.
- Reset mid-drain: the partial matrix is lost and outputs return to reset values immediately.
- Capture latency: for an edge sampled at clock edge N, `O_ROW_VLD` is 1 after edge N (from cycle N+1) if the drainer was empty.
- Throughput: one row per cycle with `I_ROW_RDY` held 1. A matrix drains in SA_R cycles. Back-to-back banks drain with no bubble.
- Earliest re-capture: a `I_OUT_VLD` rising edge in the same cycle as another bank's final-row handshake is accepted when full.
- A rising edge occurring in the first cycle after reset release compares against previous = 0 and is therefore captured.

## Test plan
- Single matrix: `I_OUT[r][c] = r*16+c`, pulse `I_OUT_VLD` one cycle, `I_ROW_RDY`=1.
  - Required: 16 consecutive rows, row r element c = r*16+c, `O_ROW_LAST` only on row 15, then `O_ROW_VLD`=0.
- Held strobe: `I_OUT_VLD` high for 40 cycles.
  - Required: exactly one matrix drained (16 handshakes), `O_OVERFLOW`=0.
- Backpressure: toggle `I_ROW_RDY` 1,0,0,1 repeating.
  - Required: no row skipped or duplicated, `O_ROW` stable during stalls, 16 handshakes total.
- Ping-pong and overflow: with `I_ROW_RDY`=0, capture matrices A (all 8'h11), B (all 8'h22), C (all 8'h33).
  - Required: `O_FULL`=1 after B, C dropped, `O_OVERFLOW`=1.
  - Release ready: output is 16 rows of 8'h11 then 16 rows of 8'h22.
- Simultaneous free/capture: full with A on row 15, assert `I_ROW_RDY` and a `I_OUT_VLD` edge carrying D (8'h44) in the same cycle.
  - Required: D accepted, `O_OVERFLOW` stays 0, drain order B then D.
- Reset mid-drain: assert `I_ASYN_RSTN`=0 at row 7.
  - Required: all outputs read reset values asynchronously.
  - After release, the next captured matrix drains from row 0.
